muldiv_unit: RTL and testbench

//  Iterative RV32M multiply/divide execution unit beside the single-cycle integer ALU.

---
 rtl/muldiv_pkg.sv | 15 +
 rtl/muldiv_unit.sv | 100 ++++++++++
 tb/tb_muldiv_unit.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: funct3 codes, FSM state type and constants shared by the RV32M multiply/divide unit.
package muldiv_pkg;
   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {IDLE, CALC, FINISH} md_state_t;

   localparam logic [63:0] DIV0_QUOT = '1;
endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, one shift-add or restoring shift-subtract step per cycle
// on a shared 2W-bit accumulator; fixed latency of DATA_WIDTH+1 cycles from accept to done.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [2:0]            Funct3,
   input  logic [DATA_WIDTH-1:0] SrcA,
   input  logic [DATA_WIDTH-1:0] SrcB,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] MulDivResult
);
   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH);
   localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

   md_state_t      state_q, state_d;
   logic [2:0]     f3_q;
   logic [2*W-1:0] acc_q, acc_d, prod;
   logic [W-1:0]   opnd_q, res_q, res_d;
   logic [CW-1:0]  cnt_q;
   logic           neg_q, div0_q, ovf_q;
   logic           a_sgn, b_sgn, neg_in, ovf_in, last, is_div, is_rem, mul_hi;
   logic [W-1:0]   abs_a, abs_b, rq_val, rq_sgn;
   logic [W+1:0]   add_a, add_b, sum;

   assign a_sgn  = SrcA[W-1] & (Funct3 inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM});
   assign b_sgn  = SrcB[W-1] & (Funct3 inside {F3_MULH, F3_DIV, F3_REM});
   assign abs_a  = a_sgn ? -SrcA : SrcA;
   assign abs_b  = b_sgn ? -SrcB : SrcB;
   assign neg_in = (Funct3 == F3_REM) ? a_sgn : a_sgn ^ b_sgn;
   assign ovf_in = (Funct3 inside {F3_DIV, F3_REM}) && SrcA == SMIN && SrcB == '1;

   assign is_div = f3_q[2];
   assign is_rem = f3_q inside {F3_REM, F3_REMU};
   assign mul_hi = f3_q inside {F3_MULH, F3_MULHSU, F3_MULHU};
   assign last   = cnt_q == CW'(W - 1);

   // Divide uses the W+2-bit adder as a subtractor; the top bit is the borrow of the trial subtract.
   assign add_a = is_div ? {1'b0, acc_q[2*W-1:W-1]} : {2'b00, acc_q[2*W-1:W]};
   assign add_b = {2'b00, opnd_q};
   assign sum   = add_a + (is_div ? ~add_b : add_b) + {{(W+1){1'b0}}, is_div};
   assign acc_d = is_div ? (sum[W+1] ? {acc_q[2*W-2:0], 1'b0} : {sum[W-1:0], acc_q[W-2:0], 1'b1})
                         : (acc_q[0] ? {sum[W:0], acc_q[W-1:1]} : {1'b0, acc_q[2*W-1:1]});

   assign prod   = neg_q ? -acc_d : acc_d;
   assign rq_val = is_rem ? acc_d[2*W-1:W] : acc_d[W-1:0];
   assign rq_sgn = neg_q ? -rq_val : rq_val;
   assign res_d  = !is_div             ? (mul_hi ? prod[2*W-1:W] : prod[W-1:0]) :
                   (div0_q && !is_rem) ? DIV0_QUOT[W-1:0] :
                   ovf_q               ? (is_rem ? '0 : SMIN) : rq_sgn;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = start ? CALC : IDLE;
         CALC:    state_d = last ? FINISH : CALC;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         f3_q    <= '0;
         acc_q   <= '0;
         opnd_q  <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         div0_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && start) begin
            f3_q   <= Funct3;
            acc_q  <= {{W{1'b0}}, Funct3[2] ? abs_a : abs_b};
            opnd_q <= Funct3[2] ? abs_b : abs_a;
            neg_q  <= neg_in;
            div0_q <= SrcB == '0;
            ovf_q  <= ovf_in;
            cnt_q  <= '0;
         end
         if (state_q == CALC) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CW'(1);
            if (last) res_q <= res_d;
         end
      end
   end

   assign busy         = state_q != IDLE;
   assign done         = state_q == FINISH;
   assign MulDivResult = res_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed scoreboard bench for muldiv_unit against an arithmetic reference.
module tb_muldiv_unit;
   logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
   logic [2:0]  Funct3 = '0;
   logic [31:0] SrcA = '0, SrcB = '0;
   logic        busy, done;
   logic [31:0] MulDivResult;

   typedef struct {
      logic [31:0] res;
      logic [2:0]  f;
      logic [31:0] a, b;
      int          cyc;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   cyc = 0, tests = 0, fails = 0, blo = 1, bhi = 0, zchk = -1, last_k = 0;
   bit   armed = 1'b0;

   muldiv_unit #(.DATA_WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .Funct3(Funct3), .SrcA(SrcA), .SrcB(SrcB),
      .busy(busy), .done(done), .MulDivResult(MulDivResult)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] sa, sb, ua, ub, p;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'h0, a};
      ub = {32'h0, b};
      case (f)
         3'd1:    p = sa * sb;
         3'd2:    p = sa * ub;
         default: p = ua * ub;
      endcase
      if (!f[2]) return (f == 3'd0) ? p[31:0] : p[63:32];
      if (b == 32'h0) return f[1] ? a : 32'hFFFF_FFFF;
      if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'h0 : 32'h8000_0000;
      case (f)
         3'd4:    return 32'($signed(a) / $signed(b));
         3'd5:    return a / b;
         3'd6:    return 32'($signed(a) % $signed(b));
         default: return a % b;
      endcase
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(5))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(15));
         default: return $urandom;
      endcase
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) next_cycle();
   endtask

   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      int n = 0;
      while (busy) begin
         if (n++ > 200) begin
            $display("FAIL issue_timeout busy stuck at %b, want 0 within 200 cycles", busy);
            $fatal(1);
         end
         next_cycle();
      end
      start  = 1'b1;
      Funct3 = f;
      SrcA   = a;
      SrcB   = b;
      last_k = cyc;
      blo    = cyc + 1;
      bhi    = cyc + 33;
      q.push_back('{ref_model(f, a, b), f, a, b, cyc + 33});
      next_cycle();
      start  = 1'b0;
      Funct3 = 3'($urandom_range(7));
      SrcA   = $urandom;
      SrcB   = $urandom;
   endtask

   always @(negedge clk) begin
      if (reset) q.delete();
      else if (armed) begin
         tests++;
         if (busy !== (cyc >= blo && cyc <= bhi)) begin
            fails++;
            $display("FAIL busy cyc=%0d got %b want %b", cyc, busy, (cyc >= blo && cyc <= bhi));
         end
         if (cyc == zchk) begin
            tests++;
            if (done !== 1'b0 || MulDivResult !== 32'h0) begin
               fails++;
               $display("FAIL reset_state got done=%b result=%h want done=0 result=00000000", done, MulDivResult);
            end
         end
         if (done) begin
            tests++;
            if (q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_done cyc=%0d got done=1 want done=0", cyc);
            end else begin
               e = q.pop_front();
               if (cyc != e.cyc) begin
                  fails++;
                  $display("FAIL done_cycle got %0d want %0d", cyc, e.cyc);
               end
               tests++;
               if (MulDivResult !== e.res) begin
                  fails++;
                  $display("FAIL result f3=%0d a=%h b=%h got %h want %h", e.f, e.a, e.b, MulDivResult, e.res);
               end
            end
         end
      end
   end

   initial begin
      repeat (3) next_cycle();
      reset = 1'b0;
      zchk  = cyc;
      armed = 1'b1;
      next_cycle();
      issue(3'd0, 32'h0000_0007, 32'hFFFF_FFFD);
      issue(3'd1, 32'h8000_0000, 32'h8000_0000);
      issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      issue(3'd4, 32'hFFFF_FFF9, 32'h0000_0002);
      issue(3'd6, 32'hFFFF_FFF9, 32'h0000_0002);
      issue(3'd5, 32'd100, 32'd7);
      issue(3'd7, 32'd100, 32'd7);
      issue(3'd4, 32'h0BAD_F00D, 32'h0);
      issue(3'd7, 32'h0000_1234, 32'h0);
      issue(3'd6, 32'h8765_4321, 32'h0);
      issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
      issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
      // Starts while busy and in the done cycle must be dropped.
      issue(3'd0, 32'd1234, 32'd5678);
      wait_to(last_k + 5);
      start = 1'b1; Funct3 = 3'd5; SrcA = 32'd99; SrcB = 32'd3;
      next_cycle();
      start = 1'b0;
      wait_to(last_k + 33);
      start = 1'b1; Funct3 = 3'd1; SrcA = 32'h7FFF_FFFF; SrcB = 32'd9;
      next_cycle();
      start = 1'b0;
      // Reset mid-divide aborts it; a fresh multiply must then complete normally.
      issue(3'd4, 32'd1000, 32'd7);
      wait_to(last_k + 10);
      reset = 1'b1;
      blo   = 1;
      bhi   = 0;
      next_cycle();
      reset = 1'b0;
      zchk  = cyc;
      issue(3'd0, 32'd3, 32'd4);
      for (int i = 0; i < 40; i++) begin
         issue(3'($urandom_range(7)), pick(), pick());
         repeat ($urandom_range(2)) next_cycle();
      end
      for (int n = 0; q.size() != 0; n++) begin
         if (n > 200) begin
            $display("FAIL drain_timeout pending=%0d want 0", q.size());
            $fatal(1);
         end
         next_cycle();
      end
      repeat (3) next_cycle();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
